ctrl_pipeline_nd: RTL and testbench
===================================

// Module: ctrl_pipeline_nd
// PURPOSE
//  Parametrised valid/control pipeline for conv/pool datapaths. Tracks per-lane valid bits and a shared tag
//  through DEPTH internal stages plus a registered output, in lock-step with an external arithmetic pipeline.
//  Adds stall (hold), flush (kill in-flight beats), a busy flag and per-stage valid visibility for datapath enables.
// PARAMETERS
//  DEPTH  4  number of internal stages (>=1); latency valid_in->valid_out = DEPTH+1 cycles when not stalled
//  LANES  1  independent valid bits per beat (>=1); all lanes share stall/flush/tag
//  TAG_W  4  width of sideband tag carried with each beat (>=1)
// PORTS
//  clk             in   1            rising-edge clock
//  rst             in   1            synchronous, active-high reset
//  valid_in        in   LANES        per-lane valid of incoming beat
//  tag_in          in   TAG_W        sideband tag of incoming beat
//  stall           in   1            1 = freeze all stages and output registers
//  flush           in   1            1 = clear all valids on next edge
//  in_ready        out  1            combinational ~stall & ~flush; beat accepted only when 1
//  valid_pipeline  out  DEPTH*LANES  stage k valids at bits [k*LANES +: LANES], stage 0 first
//  valid_out       out  LANES        registered output valids
//  tag_out         out  TAG_W        tag aligned with valid_out
//  busy            out  1            |valid_pipeline | |valid_out (combinational)
// BEHAVIOUR
//  - Reset (rst=1 at edge): valid_pipeline=0, valid_out=0, tag stages=0, tag_out=0; overrides stall/flush.
//  - Advance (stall=0, flush=0): stage0<=valid_in/tag_in; stage k<=stage k-1; valid_out/tag_out<=stage DEPTH-1.
//  - Tags shift on every advance regardless of valid; tag_out is don't-care when valid_out=0 (bench ignores).
//  - Stall (stall=1, flush=0): every valid and tag register holds; valid_in/tag_in ignored (beat dropped).
//  - Flush (flush=1): all valid regs incl. valid_out cleared next edge; tags hold; priority rst > flush > stall.
//  - Beat presented with flush=1 is dropped; beat with valid_in=0 still advances as a bubble.
//  - No FSM: pure shift structure; no wrap-around, no full condition; one beat per cycle max.
//  - Lanes independent in valid only; a beat with some lanes 0 propagates those zeros unchanged.
//  - Reset mid-operation: all in-flight beats lost; first beat after rst release appears DEPTH+1 cycles later.
//  - Stall release: pipeline resumes from held state; no beat duplicated or skipped.
// CONFIGURATION
//  CTRL_PIPE_OCCUPANCY_EN defined: extra port occupancy out $clog2(DEPTH+2) = number of stages (incl. output
//   reg) with any lane valid; combinational popcount of current register state; 0 in/after reset and flush.
//  Not defined: port and logic absent; all other behaviour identical.
// TESTING (DEPTH=4, LANES=2, TAG_W=4 unless stated)
//  1 rst=1 two cycles, random inputs -> valid_pipeline=0, valid_out=0, tag_out=0, busy=0.
//  2 valid_in=2'b01 tag=4'hA one cycle (cycle 0) -> stage k valid=01 at cycle k+1; valid_out=01, tag_out=A only at cycle 5.
//  3 8 back-to-back beats tags 0..7, valid 11 -> valid_out=11 cycles 5..12, tags 0..7 in order, busy deasserts cycle 13.
//  4 beat in stage 2, stall=1 three cycles, valid_in=11 during stall -> in_ready=0, valid_out delayed 3 cycles,
//    stalled beats never appear.
//  5 three beats in flight, flush=1 and stall=1 same cycle -> next cycle all valids 0, busy=0; beat in flush cycle dropped.
//  6 rst=1 for one cycle with 4 beats in flight, then new beat tag=3 -> only tag=3 appears, 5 cycles after rst release;
//    with CTRL_PIPE_OCCUPANCY_EN occupancy tracks 4->0->1..1->0.

Source files
------------

// File: rtl/ctrl_pipeline_nd.sv
// Valid/tag control pipeline: DEPTH stages plus an output register, with stall/flush.
// Optional occupancy count when CTRL_PIPE_OCCUPANCY_EN is defined.
module ctrl_pipeline_nd #(
  parameter int DEPTH = 4,
  parameter int LANES = 1,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES-1:0]         valid_in,
  input  logic [TAG_W-1:0]         tag_in,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     in_ready,
  output logic [DEPTH*LANES-1:0]   valid_pipeline,
  output logic [LANES-1:0]         valid_out,
  output logic [TAG_W-1:0]         tag_out,
`ifdef CTRL_PIPE_OCCUPANCY_EN
  output logic [$clog2(DEPTH+2)-1:0] occupancy,
`endif
  output logic                     busy
);

  localparam int NV = (DEPTH + 1) * LANES;
  localparam int NT = (DEPTH + 1) * TAG_W;

  // Output register is the top slice of one shift chain.
  logic [NV-1:0] vld_q, vld_d;
  logic [NT-1:0] tag_q, tag_d;

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (flush) begin
      vld_d = '0;
    end else if (!stall) begin
      vld_d = {vld_q[NV-LANES-1:0], valid_in};
      tag_d = {tag_q[NT-TAG_W-1:0], tag_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign in_ready       = ~stall & ~flush;
  assign valid_pipeline = vld_q[DEPTH*LANES-1:0];
  assign valid_out      = vld_q[NV-1 -: LANES];
  assign tag_out        = tag_q[NT-1 -: TAG_W];
  assign busy           = |vld_q;

`ifdef CTRL_PIPE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(DEPTH + 2);
  logic [OCC_W-1:0] occ;

  always_comb begin
    occ = '0;
    for (int k = 0; k <= DEPTH; k++) begin
      occ = occ + OCC_W'(|vld_q[k*LANES +: LANES]);
    end
  end

  assign occupancy = occ;
`endif

endmodule

// File: tb/tb_ctrl_pipeline_nd.sv
// Directed bench for ctrl_pipeline_nd (DEPTH=4, LANES=2, TAG_W=4).
// Occupancy checks compile in with CTRL_PIPE_OCCUPANCY_EN.
module tb_ctrl_pipeline_nd;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] valid_in;
  logic [3:0] tag_in;
  logic       stall;
  logic       flush;
  logic       in_ready;
  logic [7:0] valid_pipeline;
  logic [1:0] valid_out;
  logic [3:0] tag_out;
  logic       busy;
`ifdef CTRL_PIPE_OCCUPANCY_EN
  logic [2:0] occupancy;
`endif

  int checks   = 0;
  int failures = 0;

  ctrl_pipeline_nd #(
    .DEPTH(4),
    .LANES(2),
    .TAG_W(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .tag_in         (tag_in),
    .stall          (stall),
    .flush          (flush),
    .in_ready       (in_ready),
    .valid_pipeline (valid_pipeline),
    .valid_out      (valid_out),
    .tag_out        (tag_out),
`ifdef CTRL_PIPE_OCCUPANCY_EN
    .occupancy      (occupancy),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with random inputs
    rst      = 1'b1;
    valid_in = 2'($urandom_range(0, 3));
    tag_in   = 4'($urandom_range(0, 15));
    stall    = 1'($urandom_range(0, 1));
    flush    = 1'($urandom_range(0, 1));
    tick();
    valid_in = 2'($urandom_range(0, 3));
    tag_in   = 4'($urandom_range(0, 15));
    tick();
    chk("rst_vp", 32'(valid_pipeline), 0);
    chk("rst_vo", 32'(valid_out), 0);
    chk("rst_tag", 32'(tag_out), 0);
    chk("rst_busy", 32'(busy), 0);
`ifdef CTRL_PIPE_OCCUPANCY_EN
    chk("rst_occ", 32'(occupancy), 0);
`endif
    rst      = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    valid_in = 2'b00;
    tag_in   = 4'h0;
    #1;
    chk("rdy_idle", 32'(in_ready), 1);

    // 2: single beat walks through the stages
    valid_in = 2'b01;
    tag_in   = 4'hA;
    tick();
    valid_in = 2'b00;
    tag_in   = 4'h0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) tick();
      chk("t2_vp", 32'(valid_pipeline),
          (c <= 4) ? (1 << (2 * (c - 1))) : 0);
      chk("t2_vo", 32'(valid_out), (c == 5) ? 1 : 0);
      if (c == 5) chk("t2_tag", 32'(tag_out), 'hA);
    end
    tick();
    chk("t2_busy", 32'(busy), 0);

    // 3: eight back-to-back beats
    for (int c = 1; c <= 13; c++) begin
      if (c - 1 < 8) begin
        valid_in = 2'b11;
        tag_in   = 4'(c - 1);
      end else begin
        valid_in = 2'b00;
        tag_in   = 4'h0;
      end
      tick();
      if (c >= 5 && c <= 12) begin
        chk("t3_vo", 32'(valid_out), 3);
        chk("t3_tag", 32'(tag_out), 32'(c - 5));
        chk("t3_busy", 32'(busy), 1);
      end
      if (c == 13) begin
        chk("t3_vo_end", 32'(valid_out), 0);
        chk("t3_busy_end", 32'(busy), 0);
      end
    end

    // 4: stall with beat in stage 2
    valid_in = 2'b11;
    tag_in   = 4'h5;
    tick();
    valid_in = 2'b00;
    tag_in   = 4'h0;
    tick();
    tick();
    chk("t4_pre", 32'(valid_pipeline), 'h30);
    stall    = 1'b1;
    valid_in = 2'b11;
    tag_in   = 4'hF;
    #1;
    chk("t4_rdy", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold", 32'(valid_pipeline), 'h30);
      chk("t4_vo", 32'(valid_out), 0);
    end
    stall    = 1'b0;
    valid_in = 2'b00;
    tag_in   = 4'h0;
    tick();
    chk("t4_s3", 32'(valid_pipeline), 'hC0);
    chk("t4_vo7", 32'(valid_out), 0);
    tick();
    chk("t4_vo8", 32'(valid_out), 3);
    chk("t4_tag8", 32'(tag_out), 'h5);
    chk("t4_vp8", 32'(valid_pipeline), 0);
    tick();
    chk("t4_busy", 32'(busy), 0);

    // 5: flush with stall, three beats in flight
    valid_in = 2'b11;
    tag_in   = 4'h1;
    tick();
    valid_in = 2'b10;
    tag_in   = 4'h2;
    tick();
    valid_in = 2'b01;
    tag_in   = 4'h3;
    tick();
    chk("t5_pre", 32'(valid_pipeline), 'h39);
    flush    = 1'b1;
    stall    = 1'b1;
    valid_in = 2'b11;
    tag_in   = 4'h9;
    #1;
    chk("t5_rdy", 32'(in_ready), 0);
    tick();
    chk("t5_vp", 32'(valid_pipeline), 0);
    chk("t5_vo", 32'(valid_out), 0);
    chk("t5_busy", 32'(busy), 0);
`ifdef CTRL_PIPE_OCCUPANCY_EN
    chk("t5_occ", 32'(occupancy), 0);
`endif
    flush    = 1'b0;
    stall    = 1'b0;
    valid_in = 2'b00;
    tag_in   = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_drop", 32'(busy), 0);
    end

    // 6: reset mid-operation
    for (int i = 1; i <= 4; i++) begin
      valid_in = 2'b11;
      tag_in   = 4'(i);
      tick();
    end
    chk("t6_full", 32'(valid_pipeline), 'hFF);
`ifdef CTRL_PIPE_OCCUPANCY_EN
    chk("t6_occ4", 32'(occupancy), 4);
`endif
    rst      = 1'b1;
    valid_in = 2'b11;
    tag_in   = 4'h7;
    tick();
    chk("t6_rvp", 32'(valid_pipeline), 0);
    chk("t6_rbusy", 32'(busy), 0);
`ifdef CTRL_PIPE_OCCUPANCY_EN
    chk("t6_occ0", 32'(occupancy), 0);
`endif
    rst      = 1'b0;
    valid_in = 2'b11;
    tag_in   = 4'h3;
    tick();
    valid_in = 2'b00;
    tag_in   = 4'h0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      chk("t6_vo", 32'(valid_out), (c == 5) ? 3 : 0);
      if (c == 5) chk("t6_tag", 32'(tag_out), 'h3);
      chk("t6_busy", 32'(busy), (c <= 5) ? 1 : 0);
`ifdef CTRL_PIPE_OCCUPANCY_EN
      chk("t6_occ", 32'(occupancy), (c <= 5) ? 1 : 0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
